seq_divider_32: RTL and testbench
=================================

Name: seq_divider_32

Overview:
- Sequential unsigned restoring divider. It is the inverse-operation companion to the Vedic multiplier datapath.
- Accepts one dividend/divisor pair through a valid/ready handshake and iterates one quotient bit per clock.
- Returns the quotient and remainder through a second valid/ready handshake.
- Used to check multiplier products (product / operand == other operand, remainder 0) and for general integer division in the arithmetic subsystem.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept a new operation.
- dividend  input  WIDTH  unsigned numerator.
- divisor  input  WIDTH  unsigned denominator.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  floor(dividend/divisor).
- remainder  output  WIDTH  dividend mod divisor.
- div_by_zero  output  1  result belongs to a divisor==0 operation.

Behaviour:
- Reset:
  - One clock and one reset: clk, with rst synchronous and active-high.
  - rst sampled high at a rising edge: state=IDLE, in_ready=1 in the following cycle, out_valid=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0.
  - rst overrides all other inputs, including mid-CALC and mid-DONE. Any in-flight operation is discarded with no output.
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - Input handshake at an edge where in_valid && in_ready.
  - Latch dividend into the quotient/shift register Q, latch divisor into D, clear the partial remainder R (WIDTH+1 bits), and set iteration counter cnt=WIDTH-1.
  - divisor!=0: go to CALC.
  - divisor==0: go directly to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1 (latency 1 edge).
- CALC, one iteration per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}.
  - T non-negative (MSB 0): R=T, Q={Q[WIDTH-2:0],1}.
  - Otherwise: R={R[WIDTH-1:0],Q[WIDTH-1]}, Q={Q[WIDTH-2:0],0}.
  - If cnt==0: go to DONE and present quotient=Q_new, remainder=R_new[WIDTH-1:0], div_by_zero=0. Else cnt=cnt-1.
  - Inputs are ignored in CALC; in_ready is 0.
- Latency:
  - Input handshake at edge k gives out_valid high after edge k+WIDTH (32 edges for default).
  - Divide-by-zero: out_valid high after edge k+1.
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_valid=1 && out_ready=0; there is no limit on back-pressure duration.
  - Output handshake at an edge where out_valid && out_ready: go to IDLE. Output data registers keep their last values, but are only meaningful while out_valid=1.
  - A new input is not accepted in the same edge as the output handshake. in_ready rises the cycle after, so back-to-back throughput is one operation per WIDTH+2 cycles.
- Arithmetic:
  - Unsigned only.
  - The partial remainder is WIDTH+1 bits so the comparison never overflows for divisor up to 2^WIDTH-1.
  - Invariant at DONE (divisor!=0): quotient*divisor + remainder == dividend and remainder < divisor.
- Boundary cases:
  - dividend < divisor: quotient 0, remainder=dividend.
  - divisor==1: quotient=dividend, remainder 0.
  - dividend==0: quotient 0, remainder 0, full WIDTH latency (no early exit).
  - in_valid held high in CALC/DONE: no effect, no capture.
  - Operand changes after acceptance: no effect.

Test Plan:
- Reset, then 100/7 accepted at edge k -> out_valid first high after edge k+32; quotient=14, remainder=2, div_by_zero=0; in_ready=0 throughout CALC.
- 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF/0xFFFFFFFF -> quotient=1, remainder=0. Then 5/9 -> quotient=0, remainder=5.
- 1234/0 -> out_valid after 1 edge; quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1. Next op 10/3 -> quotient=3, remainder=1, div_by_zero=0.
- 1000/10 with out_ready held low 20 cycles after out_valid -> outputs stable at quotient=100, remainder=0 for all 20 cycles, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- rst asserted 10 cycles into CALC of 500/3 -> next cycle out_valid=0, in_ready=1, outputs 0. Following 7/2 -> quotient=3, remainder=1, with no trace of the aborted op.
- 1000 random pairs issued back-to-back with in_valid and out_ready always high -> each result satisfies q*d+r==n and r<d. Spacing between input handshakes is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/seq_divider_32.sv
// -----------------------------------------------------------------------------
// seq_divider_32
// Sequential unsigned restoring divider. One dividend/divisor pair is accepted
// through a valid/ready handshake, one quotient bit is resolved per clock, and
// the quotient/remainder pair is returned through a second valid/ready
// handshake. A zero divisor skips the iterations and returns a flagged result.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   in_valid     dividend/divisor present
//   in_ready     block can accept a new operation (state IDLE)
//   dividend     unsigned numerator, WIDTH bits
//   divisor      unsigned denominator, WIDTH bits
//   out_valid    result present (state DONE)
//   out_ready    consumer accepts the result
//   quotient     floor(dividend / divisor), all ones on divide-by-zero
//   remainder    dividend mod divisor, dividend on divide-by-zero
//   div_by_zero  result belongs to a divisor == 0 operation
// -----------------------------------------------------------------------------
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // latched divisor
    logic [WIDTH-1:0] r_q, r_d;          // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;      // iterations left after the current one
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The shifted remainder and the trial subtraction are WIDTH+1 bits wide so
    // the borrow is never lost, even for a divisor of 2^WIDTH-1. The stored
    // remainder only needs WIDTH bits: after each step it is below the divisor.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign shifted = {r_q, q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_q};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = CNT_INIT;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_DONE: begin
                // Results hold for as long as the consumer stalls.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_32
// Directed bench for seq_divider_32 (WIDTH = 32): reset state, latency,
// boundary quotients, divide-by-zero, back-pressure, mid-operation reset and a
// back-to-back run of pseudo-random operand pairs.
// -----------------------------------------------------------------------------
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; drive and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation (in_valid stays high and operands are scrambled after
    // acceptance) and check latency and result. Leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int lat;
        bit saw_ready;
        check({tag, ".in_ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        tick();
        dividend  = ~n;
        divisor   = d ^ 32'h5A5A_0001;
        lat       = 0;
        saw_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            saw_ready |= in_ready;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        if (edbz) check({tag, ".latency_le1"}, 64'(lat <= 1), 64'd1);
        else      check({tag, ".latency"}, 64'(lat), 64'd32);
        check({tag, ".in_ready_calc"}, 64'(saw_ready), 64'd0);
        check({tag, ".out_valid"},     64'(out_valid), 64'd1);
        check({tag, ".quotient"},      64'(quotient), 64'(eq));
        check({tag, ".remainder"},     64'(remainder), 64'(er));
        check({tag, ".div_by_zero"},   64'(div_by_zero), 64'(edbz));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_after"},  64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] n, d, cn, cd;
        int          w, t, t_prev;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        t_prev    = 0;
        tick();
        tick();
        check("reset.in_ready",    64'(in_ready), 64'd1);
        check("reset.out_valid",   64'(out_valid), 64'd0);
        check("reset.quotient",    64'(quotient), 64'd0);
        check("reset.remainder",   64'(remainder), 64'd0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        tick();

        // Basic division and latency.
        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        release_out("100/7");

        // Boundary quotients.
        run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        release_out("max/1");
        run_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        release_out("max/max");
        run_op("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        release_out("5/9");
        run_op("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        release_out("0/5");
        run_op("big/small", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0);
        release_out("big/small");

        // Divide by zero, then a normal op to clear the flag.
        run_op("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        release_out("1234/0");
        run_op("10/3", 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
        release_out("10/3");

        // Back-pressure: result must hold for 20 stalled cycles.
        run_op("1000/10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall.out_valid", 64'(out_valid), 64'd1);
            check("stall.in_ready",  64'(in_ready), 64'd0);
            check("stall.quotient",  64'(quotient), 64'd100);
            check("stall.remainder", 64'(remainder), 64'd0);
        end
        release_out("1000/10");

        // Reset 10 cycles into an operation.
        in_valid = 1'b1;
        dividend = 32'd500;
        divisor  = 32'd3;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out_valid",   64'(out_valid), 64'd0);
        check("abort.in_ready",    64'(in_ready), 64'd1);
        check("abort.quotient",    64'(quotient), 64'd0);
        check("abort.remainder",   64'(remainder), 64'd0);
        check("abort.div_by_zero", 64'(div_by_zero), 64'd0);
        run_op("7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
        release_out("7/2");

        // Back-to-back pseudo-random pairs with both handshakes always enabled.
        n = $urandom;
        d = $urandom >> $urandom_range(0, 31);
        if (d == '0) d = 32'd1;
        dividend  = n;
        divisor   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            w = 0;
            while (!in_ready && w < 100) begin
                tick();
                w++;
            end
            tick();
            t = cyc;
            if (i > 0) check("rnd.spacing", 64'(t - t_prev), 64'd34);
            t_prev = t;
            cn = n;
            cd = d;
            n = $urandom;
            d = $urandom >> $urandom_range(0, 31);
            if (d == '0) d = 32'd1;
            dividend = n;
            divisor  = d;
            w = 0;
            while (!out_valid && w < 100) begin
                tick();
                w++;
            end
            check("rnd.quotient",  64'(quotient), 64'(cn / cd));
            check("rnd.remainder", 64'(remainder), 64'(cn % cd));
            check("rnd.identity",  64'(quotient) * 64'(cd) + 64'(remainder), 64'(cn));
            check("rnd.rem_lt_div", 64'(remainder < cd), 64'd1);
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
